axil_reg_initiator: RTL and testbench

AXIL_REG_INITIATOR -- requirements
Module: axil_reg_initiator

---
 rtl/axil_reg_initiator.sv | 239 +++++++++++++++++++++++
 tb/tb_axil_reg_initiator.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_initiator.sv
`default_nettype none
// ============================================================================
// Module   : axil_reg_initiator
// Brief    : Single-outstanding AXI4-Lite register initiator (command -> AXI -> response).
//            Optional watchdog recovery enabled by defining AXIL_INIT_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module axil_reg_initiator #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_DPHASE_TIMEOUT   = 8
) (
    input  logic                            s_axi_aclk,
    input  logic                            s_axi_aresetn,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_wr,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   req_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   req_wdata,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_timeout,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic                            m_axi_arvalid,
    input  logic                            m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                      m_axi_rresp,
    input  logic                            m_axi_rvalid,
    output logic                            m_axi_rready
);

    if (C_M_AXI_DATA_WIDTH != 32 || C_DPHASE_TIMEOUT < 1 || C_DPHASE_TIMEOUT > 255) begin : g_param_check
        $error("axil_reg_initiator: unsupported parameter value");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_AW_W = 3'd1,
        S_WR_B    = 3'd2,
        S_RD_AR   = 3'd3,
        S_RD_R    = 3'd4,
        S_RSP     = 3'd5
    } state_t;

    state_t                          r_state,     w_state;
    logic                            r_req_ready, w_req_ready;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   r_addr,      w_addr;
    logic [C_M_AXI_DATA_WIDTH-1:0]   r_wdata,     w_wdata;
    logic                            r_awvalid,   w_awvalid;
    logic                            r_wvalid,    w_wvalid;
    logic                            r_bready,    w_bready;
    logic                            r_arvalid,   w_arvalid;
    logic                            r_rready,    w_rready;
    logic                            r_rsp_valid, w_rsp_valid;
    logic [C_M_AXI_DATA_WIDTH-1:0]   r_rsp_rdata, w_rsp_rdata;
    logic [1:0]                      r_rsp_resp,  w_rsp_resp;
`ifdef AXIL_INIT_TIMEOUT_EN
    logic                            r_rsp_tmo,   w_rsp_tmo;
    logic [7:0]                      r_tmo_cnt;
    localparam logic [7:0] c_tmo_last = 8'(C_DPHASE_TIMEOUT - 1);
`endif

    always_comb begin
        w_state     = r_state;
        w_req_ready = r_req_ready;
        w_addr      = r_addr;
        w_wdata     = r_wdata;
        w_awvalid   = r_awvalid;
        w_wvalid    = r_wvalid;
        w_bready    = r_bready;
        w_arvalid   = r_arvalid;
        w_rready    = r_rready;
        w_rsp_valid = r_rsp_valid;
        w_rsp_rdata = r_rsp_rdata;
        w_rsp_resp  = r_rsp_resp;
`ifdef AXIL_INIT_TIMEOUT_EN
        w_rsp_tmo   = r_rsp_tmo;
`endif
        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid && r_req_ready) begin
                    w_req_ready = 1'b0;
                    w_addr      = req_addr;
                    w_wdata     = req_wdata;
                    if (req_wr) begin
                        w_state   = S_WR_AW_W;
                        w_awvalid = 1'b1;
                        w_wvalid  = 1'b1;
                    end else begin
                        w_state   = S_RD_AR;
                        w_arvalid = 1'b1;
                    end
                end
            end
            S_WR_AW_W: begin
                // AW and W retire independently; B phase starts once both are gone
                if (r_awvalid && m_axi_awready) w_awvalid = 1'b0;
                if (r_wvalid && m_axi_wready)   w_wvalid  = 1'b0;
                if (!w_awvalid && !w_wvalid) begin
                    w_state  = S_WR_B;
                    w_bready = 1'b1;
                end
            end
            S_WR_B: begin
                if (m_axi_bvalid) begin
                    w_state     = S_RSP;
                    w_bready    = 1'b0;
                    w_rsp_valid = 1'b1;
                    w_rsp_rdata = '0;
                    w_rsp_resp  = m_axi_bresp;
`ifdef AXIL_INIT_TIMEOUT_EN
                    w_rsp_tmo   = 1'b0;
`endif
                end
            end
            S_RD_AR: begin
                if (m_axi_arready) begin
                    w_state   = S_RD_R;
                    w_arvalid = 1'b0;
                    w_rready  = 1'b1;
                end
            end
            S_RD_R: begin
                if (m_axi_rvalid) begin
                    w_state     = S_RSP;
                    w_rready    = 1'b0;
                    w_rsp_valid = 1'b1;
                    w_rsp_rdata = m_axi_rdata;
                    w_rsp_resp  = m_axi_rresp;
`ifdef AXIL_INIT_TIMEOUT_EN
                    w_rsp_tmo   = 1'b0;
`endif
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    w_state     = S_IDLE;
                    w_rsp_valid = 1'b0;
                    w_req_ready = 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
`ifdef AXIL_INIT_TIMEOUT_EN
        // A completion on the expiry cycle still wins over the watchdog
        if (r_state != S_IDLE && r_state != S_RSP && w_state != S_RSP && r_tmo_cnt == c_tmo_last) begin
            w_state     = S_RSP;
            w_awvalid   = 1'b0;
            w_wvalid    = 1'b0;
            w_bready    = 1'b0;
            w_arvalid   = 1'b0;
            w_rready    = 1'b0;
            w_rsp_valid = 1'b1;
            w_rsp_rdata = '0;
            w_rsp_resp  = 2'b10;
            w_rsp_tmo   = 1'b1;
        end
`endif
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b00;
        end else begin
            r_state     <= w_state;
            r_req_ready <= w_req_ready;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            r_awvalid   <= w_awvalid;
            r_wvalid    <= w_wvalid;
            r_bready    <= w_bready;
            r_arvalid   <= w_arvalid;
            r_rready    <= w_rready;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_resp  <= w_rsp_resp;
        end
    end

`ifdef AXIL_INIT_TIMEOUT_EN
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            r_rsp_tmo <= 1'b0;
            r_tmo_cnt <= '0;
        end else begin
            r_rsp_tmo <= w_rsp_tmo;
            if (r_state == S_IDLE)
                r_tmo_cnt <= '0;
            else if (r_state != S_RSP)
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
        end
    end
    assign rsp_timeout = r_rsp_tmo;
`else
    assign rsp_timeout = 1'b0;
`endif

    assign req_ready     = r_req_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;
    assign m_axi_awaddr  = r_addr;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = '1;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign m_axi_araddr  = r_addr;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_axil_reg_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_axil_reg_initiator
// Brief    : Directed self-checking bench: responsive AXI-Lite slave, response
//            scoreboard and latency model for axil_reg_initiator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axil_reg_initiator;

    localparam int C_TMO = 8;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        req_valid, req_ready, req_wr;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    always #5 clk = ~clk;

    axil_reg_initiator #(
        .C_M_AXI_DATA_WIDTH (32),
        .C_M_AXI_ADDR_WIDTH (32),
        .C_DPHASE_TIMEOUT   (C_TMO)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (aresetn),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wr        (req_wr),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .rsp_timeout   (rsp_timeout),
        .m_axi_awaddr  (awaddr),
        .m_axi_awvalid (awvalid),
        .m_axi_awready (awready),
        .m_axi_wdata   (wdata),
        .m_axi_wstrb   (wstrb),
        .m_axi_wvalid  (wvalid),
        .m_axi_wready  (wready),
        .m_axi_bresp   (bresp),
        .m_axi_bvalid  (bvalid),
        .m_axi_bready  (bready),
        .m_axi_araddr  (araddr),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_rdata   (rdata),
        .m_axi_rresp   (rresp),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        tmo;
    } exp_t;
    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    // slave behaviour knobs
    int          aw_delay = 0, w_delay = 0, ar_delay = 0, rsp_delay = 0;
    logic        b_en = 1'b1, r_en = 1'b1;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = '0;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, rsp_cnt = 0;
    int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
    int          e_aw = 0, e_w = 0, e_b = 0, e_ar = 0, e_r = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // AXI-Lite slave and response consumer, updated just after each rising edge
    initial begin
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; rsp_ready = 0;
        bresp = 0; rresp = 0; rdata = 0;
        forever begin
            @(posedge clk); #1;
            if (!aresetn) begin
                awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; rsp_ready = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; rsp_cnt = 0;
            end else begin
                awready = awvalid && (aw_cnt >= aw_delay);
                if (awvalid) begin if (awready) begin n_aw++; aw_cnt = 0; end else aw_cnt++; end
                wready = wvalid && (w_cnt >= w_delay);
                if (wvalid) begin if (wready) begin n_w++; w_cnt = 0; end else w_cnt++; end
                arready = arvalid && (ar_cnt >= ar_delay);
                if (arvalid) begin if (arready) begin n_ar++; ar_cnt = 0; end else ar_cnt++; end
                bresp  = bresp_cfg;
                bvalid = bready && b_en;
                if (bvalid) n_b++;
                rresp  = rresp_cfg;
                rdata  = rdata_cfg;
                rvalid = rready && r_en;
                if (rvalid) n_r++;
                rsp_ready = rsp_valid && (rsp_cnt >= rsp_delay);
                if (rsp_valid) begin if (rsp_ready) rsp_cnt = 0; else rsp_cnt++; end
            end
        end
    end

    // per-cycle compare of response channel and bus invariants against the model
    initial begin
        logic        prev_aw;
        logic [31:0] prev_awaddr;
        prev_aw = 0; prev_awaddr = 0;
        forever begin
            @(negedge clk);
            if (aresetn) begin
                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", 64'(rsp_valid), 64'd0);
                    end else begin
                        check("rsp_rdata", 64'(rsp_rdata), 64'(exp_q[0].rdata));
                        check("rsp_resp", 64'(rsp_resp), 64'(exp_q[0].resp));
                        check("rsp_timeout", 64'(rsp_timeout), 64'(exp_q[0].tmo));
                        check("req_ready_in_rsp", 64'(req_ready), 64'd0);
                        check("axi_quiet_in_rsp", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
                        if (rsp_ready) void'(exp_q.pop_front());
                    end
                end
                if (awvalid && prev_aw) check("awaddr_stable", 64'(awaddr), 64'(prev_awaddr));
                if (awvalid || wvalid) check("wstrb", 64'(wstrb), 64'hF);
            end
            prev_aw     = awvalid;
            prev_awaddr = awaddr;
        end
    end

    task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        logic acc;
        int   t;
        t = 0;
        req_valid = 1; req_wr = wr; req_addr = addr; req_wdata = wd;
        do begin
            acc = req_ready;
            @(posedge clk); #1;
            t++;
        end while (!acc && t < 20);
        req_valid = 0;
        if (!acc) check("req_accept", 64'(acc), 64'd1);
        if (wr) begin
            check("awaddr", 64'(awaddr), 64'(addr));
            check("wdata", 64'(wdata), 64'(wd));
        end else begin
            check("araddr", 64'(araddr), 64'(addr));
        end
    endtask

    task automatic wait_rsp(output int k);
        k = 0;
        while (!rsp_valid && k < 50) begin @(posedge clk); #1; k++; end
    endtask

    task automatic wait_rsp_done();
        int t;
        t = 0;
        while (rsp_valid && t < 50) begin @(posedge clk); #1; t++; end
        check("rsp_dropped", 64'(rsp_valid), 64'd0);
        check("req_ready_after_rsp", 64'(req_ready), 64'd1);
    endtask

    task automatic check_counts();
        check("aw_beats", 64'(n_aw), 64'(e_aw));
        check("w_beats", 64'(n_w), 64'(e_w));
        check("b_beats", 64'(n_b), 64'(e_b));
        check("ar_beats", 64'(n_ar), 64'(e_ar));
        check("r_beats", 64'(n_r), 64'(e_r));
    endtask

    // full transaction; latency model: writes max(aw,w)+2, reads ar+2 (single-cycle B/R)
    task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd, input int pin_lat);
        exp_t e;
        int   k, model;
        e.rdata = wr ? 32'd0 : rdata_cfg;
        e.resp  = wr ? bresp_cfg : rresp_cfg;
        e.tmo   = 1'b0;
        exp_q.push_back(e);
        if (wr) begin e_aw++; e_w++; e_b++; end else begin e_ar++; e_r++; end
        model = wr ? ((aw_delay > w_delay ? aw_delay : w_delay) + 2) : (ar_delay + 2);
        send(wr, addr, wd);
        wait_rsp(k);
        check("latency_model", 64'(k), 64'(model));
        check("latency_pin", 64'(k), 64'(pin_lat));
        wait_rsp_done();
        check_counts();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        aresetn = 0;
        @(posedge clk); #1;
        exp_q.delete();
        aresetn = 1;
        @(posedge clk); #1;
    endtask

    initial begin
        int k, seen;
        aresetn = 0; req_valid = 0; req_wr = 0; req_addr = 0; req_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", 64'(req_ready), 64'd0);
        check("reset_outputs", 64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_timeout}), 64'd0);
        aresetn = 1;
        @(posedge clk); #1;
        check("req_ready_after_reset", 64'(req_ready), 64'd1);

        txn(1, 32'h7080_0004, 32'hDEAD_BEEF, 2);

        aw_delay = 3; w_delay = 0;
        txn(1, 32'h7080_0008, 32'h0BAD_F00D, 5);

        aw_delay = 0; ar_delay = 2; rdata_cfg = 32'h1234_5678; rresp_cfg = 2'b10;
        txn(0, 32'h7080_0010, 32'h0, 4);

        ar_delay = 0; rsp_delay = 5; rdata_cfg = 32'hA5A5_5A5A; rresp_cfg = 2'b00;
        txn(0, 32'h7080_0014, 32'h0, 2);

        rsp_delay = 0; aw_delay = 1; w_delay = 2; bresp_cfg = 2'b11;
        txn(1, 32'h7080_0018, 32'h1357_9BDF, 4);

        // slave never answers the B phase
        aw_delay = 0; w_delay = 0; bresp_cfg = 2'b00; b_en = 0;
`ifdef AXIL_INIT_TIMEOUT_EN
        begin
            exp_t e;
            e.rdata = 32'd0; e.resp = 2'b10; e.tmo = 1'b1;
            exp_q.push_back(e);
        end
        e_aw++; e_w++;
        send(1, 32'h7080_0020, 32'hCAFE_0001);
        wait_rsp(k);
        check("timeout_latency_model", 64'(k), 64'(C_TMO));
        check("timeout_latency_pin", 64'(k), 64'd8);
        wait_rsp_done();
        check_counts();
`else
        e_aw++; e_w++;
        send(1, 32'h7080_0020, 32'hCAFE_0001);
        seen = 0;
        repeat (20) begin
            if (rsp_valid) seen++;
            @(posedge clk); #1;
        end
        check("no_rsp_without_watchdog", 64'(seen), 64'd0);
        check("bready_waiting", 64'(bready), 64'd1);
        check_counts();
        do_reset();
`endif
        b_en = 1;

        // reset while waiting in the R phase
        r_en = 0;
        e_ar++;
        begin
            exp_t e;
            e.rdata = rdata_cfg; e.resp = rresp_cfg; e.tmo = 1'b0;
            exp_q.push_back(e);
        end
        send(0, 32'h7080_0030, 32'h0);
        k = 0;
        while (!rready && k < 20) begin @(posedge clk); #1; k++; end
        check("rready_reached", 64'(rready), 64'd1);
        aresetn = 0;
        @(posedge clk); #1;
        check("mid_reset_outputs", 64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid}), 64'd0);
        check("mid_reset_req_ready", 64'(req_ready), 64'd0);
        exp_q.delete();
        aresetn = 1;
        @(posedge clk); #1;
        check("req_ready_after_release", 64'(req_ready), 64'd1);
        check("no_rsp_after_release", 64'(rsp_valid), 64'd0);
        r_en = 1;

        rdata_cfg = 32'h0F0F_1234; rresp_cfg = 2'b01;
        txn(0, 32'h7080_0034, 32'h0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck, expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire
